rob_recovery_ctrl: RTL and testbench
====================================

// Module: rob_recovery_ctrl
// PURPOSE
// Sequences branch-mispredict recovery around the ROB retire stage. Watches both retire slots, commits the
// oldest mispredicted branch, and kills every younger retire. Then runs a fixed flush, one fetch redirect
// and a drain wait. Holds dispatch stalled for the whole recovery.
// PARAMETERS
// FLUSH_CYCLES   2    cycles Flush is held high (>=1)
// CNT_W          4    width of flush counter; 2**CNT_W > FLUSH_CYCLES
// DRAIN_TIMEOUT  64   max cycles spent in DRAIN before error (>=1)
// TO_W           7    width of drain counter; 2**TO_W > DRAIN_TIMEOUT
// PORTS
// CLK              in   1   clock, posedge
// RST              in   1   asynchronous, active-high reset
// Retire1_V        in   1   retire slot 1 (older) valid
// Retire1_Mispred  in   1   slot 1 is a mispredicted branch
// Retire1_NewPC    in   16  correct target for slot 1
// Retire2_V        in   1   retire slot 2 (younger) valid
// Retire2_Mispred  in   1   slot 2 is a mispredicted branch
// Retire2_NewPC    in   16  correct target for slot 2
// ROB_Empty        in   1   ROB holds no valid entries
// SB_Empty         in   1   store buffer fully drained
// Retire1_Kill     out  1   suppress slot 1 commit (combinational)
// Retire2_Kill     out  1   suppress slot 2 commit (combinational)
// Flush            out  1   flush ROB/RS/rename state (registered)
// Redirect_V       out  1   fetch redirect strobe, one cycle (registered)
// Redirect_PC      out  16  redirect target (registered)
// Dispatch_Stall   out  1   block decode/dispatch (registered)
// Recovery_Err     out  1   sticky: drain timed out
// Mispred_Count    out  16  recoveries started, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; Flush=0, Redirect_V=0, Redirect_PC=0, Dispatch_Stall=0,
//   Recovery_Err=0, Mispred_Count=0, counters=0. Reset mid-recovery abandons it with no redirect.
// - States: IDLE, FLUSH, REDIRECT, DRAIN. Registered outputs are decoded from the next state, so each
//   one is valid in the cycle its state is occupied.
// - Trigger (IDLE only): slot 1 wins if Retire1_V&Retire1_Mispred; else slot 2 if Retire2_V&Retire2_Mispred.
//   On trigger: latch that slot's NewPC, increment Mispred_Count (saturating), next state FLUSH.
//   Mispred without its _V is ignored.
// - Kill, combinational: Retire1_Kill = (state!=IDLE).
//   Retire2_Kill = (state!=IDLE) | (Retire1_V&Retire1_Mispred).
//   A mispredicted branch itself always commits; only younger slots are killed.
// - FLUSH: Flush=1, Dispatch_Stall=1 for exactly FLUSH_CYCLES cycles, then REDIRECT.
// - REDIRECT: Redirect_V=1 for exactly 1 cycle, Redirect_PC=latched PC, Flush=0, then DRAIN.
//   Redirect_PC holds its value after the strobe.
// - DRAIN: Dispatch_Stall=1. Exit to IDLE in the first cycle ROB_Empty&SB_Empty is sampled high.
//   If neither happens within DRAIN_TIMEOUT cycles, set Recovery_Err (sticky until RST) and go to IDLE.
// - Dispatch_Stall falls in the cycle IDLE is re-entered.
// - New mispredicts arriving outside IDLE are ignored (killed, no second recovery).
// - A trigger in the same cycle IDLE is re-entered is accepted normally.
// - Minimum recovery = FLUSH_CYCLES + 2 cycles (FLUSH + REDIRECT + 1 DRAIN cycle).
// TESTING
// 1. RST pulse mid-FLUSH -> all outputs 0 immediately (async); state IDLE; Mispred_Count=0.
// 2. Retire1 mispred NewPC=16'h0040 -> Retire2_Kill=1 same cycle; Flush high 2 cycles;
//    Redirect_V 1 cycle with PC=16'h0040; Mispred_Count=1.
// 3. Both slots mispred (PC1=16'h0100, PC2=16'h0200) -> Redirect_PC=16'h0100; count +1 only.
// 4. Retire2 mispred PC=16'h0300 with Retire1_V=1 and no mispred -> no kills that cycle;
//    Redirect_PC=16'h0300.
// 5. Mispred during FLUSH/DRAIN -> both kills high; no second Redirect_V; count unchanged.
// 6. DRAIN with SB_Empty=0 for 64 cycles -> Recovery_Err=1 and Dispatch_Stall=0 on exit to IDLE;
//    a variant holding Mispred_Count at 16'hFFFF confirms it stays saturated on the next trigger.

Source files
------------

// File: rtl/rob_recovery_ctrl.sv
// Branch-mispredict recovery sequencer for the ROB retire stage: commits the oldest
// mispredicted branch, kills younger retires, then runs flush, one redirect and a drain wait.
module rob_recovery_ctrl #(
  parameter int FLUSH_CYCLES  = 2,
  parameter int CNT_W         = 4,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int TO_W          = 7
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Retire1_V,
  input  logic        Retire1_Mispred,
  input  logic [15:0] Retire1_NewPC,
  input  logic        Retire2_V,
  input  logic        Retire2_Mispred,
  input  logic [15:0] Retire2_NewPC,
  input  logic        ROB_Empty,
  input  logic        SB_Empty,
  output logic        Retire1_Kill,
  output logic        Retire2_Kill,
  output logic        Flush,
  output logic        Redirect_V,
  output logic [15:0] Redirect_PC,
  output logic        Dispatch_Stall,
  output logic        Recovery_Err,
  output logic [15:0] Mispred_Count
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_DRAIN    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [TO_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [15:0]       pc_q, pc_d;
  logic [15:0]       mispred_count_q, mispred_count_d;
  logic              recovery_err_q, recovery_err_d;
  logic              flush_q, flush_d;
  logic              redirect_v_q, redirect_v_d;
  logic [15:0]       redirect_pc_q, redirect_pc_d;
  logic              dispatch_stall_q, dispatch_stall_d;

  logic              trig1_s;
  logic              trig2_s;

  assign trig1_s = Retire1_V & Retire1_Mispred;
  assign trig2_s = Retire2_V & Retire2_Mispred;

  // The mispredicted branch itself always commits; only younger slots are suppressed.
  assign Retire1_Kill = (state_q != ST_IDLE);
  assign Retire2_Kill = (state_q != ST_IDLE) | trig1_s;

  // Next-state, counters and registered-output decode from the next state.
  always_comb begin
    state_d         = state_q;
    flush_cnt_d     = flush_cnt_q;
    drain_cnt_d     = drain_cnt_q;
    pc_d            = pc_q;
    mispred_count_d = mispred_count_q;
    recovery_err_d  = recovery_err_q;

    case (state_q)
      ST_IDLE: begin
        if (trig1_s | trig2_s) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
          pc_d        = trig1_s ? Retire1_NewPC : Retire2_NewPC;
          if (mispred_count_q != 16'hFFFF) begin
            mispred_count_d = mispred_count_q + 16'd1;
          end else begin
            mispred_count_d = mispred_count_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
          state_d     = ST_REDIRECT;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_REDIRECT: begin
        state_d     = ST_DRAIN;
        drain_cnt_d = '0;
      end
      ST_DRAIN: begin
        // drain_cnt_q counts DRAIN cycles already spent before this one
        if (ROB_Empty & SB_Empty) begin
          state_d = ST_IDLE;
        end else if (drain_cnt_q == TO_W'(DRAIN_TIMEOUT - 1)) begin
          state_d        = ST_IDLE;
          recovery_err_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    flush_d          = (state_d == ST_FLUSH);
    redirect_v_d     = (state_d == ST_REDIRECT);
    dispatch_stall_d = (state_d != ST_IDLE);
    if (state_d == ST_REDIRECT) begin
      redirect_pc_d = pc_q;
    end else begin
      redirect_pc_d = redirect_pc_q;
    end
  end

  // State and output registers; reset abandons any recovery in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q          <= ST_IDLE;
      flush_cnt_q      <= '0;
      drain_cnt_q      <= '0;
      pc_q             <= 16'h0000;
      mispred_count_q  <= 16'h0000;
      recovery_err_q   <= 1'b0;
      flush_q          <= 1'b0;
      redirect_v_q     <= 1'b0;
      redirect_pc_q    <= 16'h0000;
      dispatch_stall_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      drain_cnt_q      <= drain_cnt_d;
      pc_q             <= pc_d;
      mispred_count_q  <= mispred_count_d;
      recovery_err_q   <= recovery_err_d;
      flush_q          <= flush_d;
      redirect_v_q     <= redirect_v_d;
      redirect_pc_q    <= redirect_pc_d;
      dispatch_stall_q <= dispatch_stall_d;
    end
  end

  assign Flush          = flush_q;
  assign Redirect_V     = redirect_v_q;
  assign Redirect_PC    = redirect_pc_q;
  assign Dispatch_Stall = dispatch_stall_q;
  assign Recovery_Err   = recovery_err_q;
  assign Mispred_Count  = mispred_count_q;

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Self-checking bench for rob_recovery_ctrl: directed scenarios plus random traffic,
// each compared against a recovery-age model kept here.
module tb_rob_recovery_ctrl;

  localparam int FC = 2;
  localparam int TO = 64;

  logic        CLK;
  logic        RST;
  logic        Retire1_V, Retire1_Mispred, Retire2_V, Retire2_Mispred;
  logic [15:0] Retire1_NewPC, Retire2_NewPC;
  logic        ROB_Empty, SB_Empty;
  logic        Retire1_Kill, Retire2_Kill, Flush, Redirect_V, Dispatch_Stall, Recovery_Err;
  logic [15:0] Redirect_PC, Mispred_Count;

  int n_checks;
  int n_fail;

  // reference model: a recovery is "busy" for a number of cycles measured by its age
  logic        m_busy;
  int          m_age;
  logic [15:0] m_pc;
  logic [15:0] m_rpc;
  logic        m_err;
  logic [15:0] m_cnt;

  rob_recovery_ctrl #(
    .FLUSH_CYCLES(FC), .CNT_W(4), .DRAIN_TIMEOUT(TO), .TO_W(7)
  ) dut (
    .CLK(CLK), .RST(RST),
    .Retire1_V(Retire1_V), .Retire1_Mispred(Retire1_Mispred), .Retire1_NewPC(Retire1_NewPC),
    .Retire2_V(Retire2_V), .Retire2_Mispred(Retire2_Mispred), .Retire2_NewPC(Retire2_NewPC),
    .ROB_Empty(ROB_Empty), .SB_Empty(SB_Empty),
    .Retire1_Kill(Retire1_Kill), .Retire2_Kill(Retire2_Kill),
    .Flush(Flush), .Redirect_V(Redirect_V), .Redirect_PC(Redirect_PC),
    .Dispatch_Stall(Dispatch_Stall), .Recovery_Err(Recovery_Err), .Mispred_Count(Mispred_Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_busy = 1'b0; m_age = 0; m_pc = 16'h0000; m_rpc = 16'h0000;
    m_err = 1'b0; m_cnt = 16'h0000;
  endtask

  // one clock of recovery behaviour, using the inputs seen at this edge
  task automatic model_update();
    if (!m_busy) begin
      if (Retire1_V && Retire1_Mispred) begin
        m_busy = 1'b1; m_age = 1; m_pc = Retire1_NewPC;
      end else if (Retire2_V && Retire2_Mispred) begin
        m_busy = 1'b1; m_age = 1; m_pc = Retire2_NewPC;
      end
      if (m_busy && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (m_age >= FC + 2 && ROB_Empty && SB_Empty) begin
      m_busy = 1'b0;
    end else if (m_age == FC + 1 + TO) begin
      m_busy = 1'b0; m_err = 1'b1;
    end else begin
      m_age = m_age + 1;
    end
    if (m_busy && m_age == FC + 1) m_rpc = m_pc;
  endtask

  function automatic logic [1:0] exp_kill();
    return {m_busy, m_busy | (Retire1_V & Retire1_Mispred)};
  endfunction

  function automatic logic [35:0] exp_vec();
    return {m_busy && (m_age <= FC), m_busy && (m_age == FC + 1), m_rpc, m_busy, m_err, m_cnt};
  endfunction

  function automatic logic [35:0] obs_vec();
    return {Flush, Redirect_V, Redirect_PC, Dispatch_Stall, Recovery_Err, Mispred_Count};
  endfunction

  task automatic drive(input logic r1v, input logic r1m, input logic [15:0] p1,
                       input logic r2v, input logic r2m, input logic [15:0] p2,
                       input logic rob, input logic sb);
    Retire1_V = r1v; Retire1_Mispred = r1m; Retire1_NewPC = p1;
    Retire2_V = r2v; Retire2_Mispred = r2m; Retire2_NewPC = p2;
    ROB_Empty = rob; SB_Empty = sb;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic reset_dut();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    RST = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset_dut();
    n_checks++;
    if (obs_vec() !== 36'h0 || {Retire1_Kill, Retire2_Kill} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_state: got %h kills %b, want 0 kills 00", obs_vec(), {Retire1_Kill, Retire2_Kill});
    end
    drive(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (obs_vec() !== 36'h0 || {Retire1_Kill, Retire2_Kill} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_flush: got %h kills %b, want 0 kills 00", obs_vec(), {Retire1_Kill, Retire2_Kill});
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_no_redirect: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  // Directed recovery: cycle 0 carries (s1m, s2m) mispredicts, then a drain wait of dwait cycles.
  task automatic run_recovery(input string name, input logic r1v, input logic s1m, input logic [15:0] p1,
                              input logic s2m, input logic [15:0] p2, input int dwait,
                              input logic noise, input logic [1:0] kill0,
                              input logic [15:0] want_pc, input logic [15:0] want_cnt);
    int flush_hi, rv_hi;
    logic [15:0] seen_pc;
    flush_hi = 0; rv_hi = 0; seen_pc = 16'h0000;
    for (int i = 0; i < FC + 3 + dwait; i++) begin
      if (i == 0) drive(r1v, s1m, p1, 1'b1, s2m, p2, 1'b0, 1'b0);
      else if (i < FC + 1 + dwait) drive(noise, noise, 16'hBEEF, noise, noise, 16'hCAFE, 1'b0, 1'b1);
      else drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      #1;
      n_checks++;
      if ({Retire1_Kill, Retire2_Kill} !== exp_kill()) begin
        n_fail++;
        $display("FAIL %s kills cyc %0d: got %b want %b", name, i, {Retire1_Kill, Retire2_Kill}, exp_kill());
      end
      if (i == 0) begin
        n_checks++;
        if ({Retire1_Kill, Retire2_Kill} !== kill0) begin
          n_fail++;
          $display("FAIL %s trigger_kills: got %b want %b", name, {Retire1_Kill, Retire2_Kill}, kill0);
        end
      end
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL %s outputs cyc %0d: got %h want %h", name, i, obs_vec(), exp_vec());
      end
      if (Flush) flush_hi++;
      if (Redirect_V) begin rv_hi++; seen_pc = Redirect_PC; end
    end
    n_checks++;
    if (flush_hi != FC || rv_hi != 1 || seen_pc !== want_pc || Mispred_Count !== want_cnt || Dispatch_Stall !== 1'b0) begin
      n_fail++;
      $display("FAIL %s summary: flush %0d rv %0d pc %h cnt %h stall %b, want %0d 1 %h %h 0",
               name, flush_hi, rv_hi, seen_pc, Mispred_Count, Dispatch_Stall, FC, want_pc, want_cnt);
    end
  endtask

  task automatic test_slot1();
    reset_dut();
    run_recovery("slot1", 1'b1, 1'b1, 16'h0040, 1'b0, 16'h9999, 3, 1'b0, 2'b01, 16'h0040, 16'd1);
  endtask

  task automatic test_both_slots();
    reset_dut();
    run_recovery("both", 1'b1, 1'b1, 16'h0100, 1'b1, 16'h0200, 1, 1'b0, 2'b01, 16'h0100, 16'd1);
  endtask

  task automatic test_slot2();
    reset_dut();
    run_recovery("slot2", 1'b1, 1'b0, 16'h0111, 1'b1, 16'h0300, 0, 1'b0, 2'b00, 16'h0300, 16'd1);
  endtask

  task automatic test_ignore_busy();
    reset_dut();
    run_recovery("ignore", 1'b1, 1'b1, 16'h0ABC, 1'b0, 16'h0000, 5, 1'b1, 2'b01, 16'h0ABC, 16'd1);
  endtask

  task automatic test_timeout_and_saturation();
    int stall_hi;
    reset_dut();
    stall_hi = 0;
    for (int i = 0; i < FC + 1 + TO + 3; i++) begin
      if (i == 0) drive(1'b1, 1'b1, 16'h0555, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      else drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL timeout outputs cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (Dispatch_Stall) stall_hi++;
    end
    n_checks++;
    if (Recovery_Err !== 1'b1 || Dispatch_Stall !== 1'b0 || stall_hi != FC + 1 + TO) begin
      n_fail++;
      $display("FAIL timeout summary: err %b stall %b stall_cycles %0d, want 1 0 %0d",
               Recovery_Err, Dispatch_Stall, stall_hi, FC + 1 + TO);
    end
    force dut.mispred_count_q = 16'hFFFE;
    #1;
    release dut.mispred_count_q;
    m_cnt = 16'hFFFE;
    // held mispredict retriggers on every IDLE cycle, giving back-to-back recoveries
    for (int i = 0; i < 3 * (FC + 3); i++) begin
      drive(1'b1, 1'b1, 16'(16'h0700 + 16'(i)), 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      #1;
      n_checks++;
      if ({Retire1_Kill, Retire2_Kill} !== exp_kill()) begin
        n_fail++;
        $display("FAIL b2b kills cyc %0d: got %b want %b", i, {Retire1_Kill, Retire2_Kill}, exp_kill());
      end
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b outputs cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (Mispred_Count !== 16'hFFFF || Recovery_Err !== 1'b1) begin
      n_fail++;
      $display("FAIL saturation: cnt %h err %b, want ffff 1", Mispred_Count, Recovery_Err);
    end
  endtask

  task automatic test_random();
    logic r1v, r1m, r2v, r2m, rob, sb;
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      r1v = ($urandom_range(0, 3) != 0);
      r1m = ($urandom_range(0, 9) == 0);
      r2v = ($urandom_range(0, 3) != 0);
      r2m = ($urandom_range(0, 9) == 0);
      rob = ($urandom_range(0, 2) != 0);
      sb  = ($urandom_range(0, 3) != 0);
      if (i >= 1500 && i < 1700) sb = 1'b0;
      drive(r1v, r1m, 16'($urandom), r2v, r2m, 16'($urandom), rob, sb);
      #1;
      n_checks++;
      if ({Retire1_Kill, Retire2_Kill} !== exp_kill()) begin
        n_fail++;
        $display("FAIL random kills cyc %0d: got %b want %b", i, {Retire1_Kill, Retire2_Kill}, exp_kill());
      end
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random outputs cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    test_reset();
    test_slot1();
    test_both_slots();
    test_slot2();
    test_ignore_busy();
    test_timeout_and_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
